// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants: default 640x480@60 porches, totals, sync
// polarities, pixel-drive width and the frame-buffer tile grid.
package vga_timing_gen_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Both axis counters share one width; totals must fit in it.
  localparam int CNT_W = 10;

  // Sync pulses are active-low for this mode.
  localparam logic HSYNC_ACTIVE = 1'b0;
  localparam logic VSYNC_ACTIVE = 1'b0;

  // {R1,G1,B1,R0,G0,B0}
  localparam int                RGB_W     = 6;
  localparam logic [RGB_W-1:0]  RGB_WHITE = '1;
  localparam logic [RGB_W-1:0]  RGB_BLACK = '0;

  // Frame-buffer controller tiling of the visible area.
  localparam int TILE_PX   = 40;
  localparam int TILE_COLS = 16;
  localparam int TILE_ROWS = 12;

  // Frame counter width; a divider of 1 still needs one bit of storage.
  function automatic int frame_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus visible/sync windows.
// Used once per line (always enabled) and once per frame (enabled on H wrap).
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             visible,
  output logic             sync_win
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + SYNC);

  // Position counter: advance when enabled, wrap from last position to 0.
  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

  assign visible  = (cnt < VIS_END);
  assign sync_win = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V counters, registered syncs and pixel drive,
// vertical-blank pulse and a slow sprite animation phase bit.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int ANIM_DIV  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             colour,
  output logic [CNT_W-1:0] counter_H,
  output logic [CNT_W-1:0] counter_V,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             display_on,
  output logic             vblank_start,
  output logic             anim_phase
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FC_W    = frame_cnt_w(ANIM_DIV);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VB_ROW = CNT_W'(V_VISIBLE);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(ANIM_DIV - 1);

  logic h_wrap;
  logic h_vis, v_vis;
  logic h_sync_win, v_sync_win;
  logic [FC_W-1:0] frame_cnt;

  // Line advances on the same clk the pixel counter wraps.
  assign h_wrap = (counter_H == H_LAST);

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .en       (1'b1),
    .cnt      (counter_H),
    .visible  (h_vis),
    .sync_win (h_sync_win)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .en       (h_wrap),
    .cnt      (counter_V),
    .visible  (v_vis),
    .sync_win (v_sync_win)
  );

  assign display_on   = h_vis && v_vis;
  assign vblank_start = (counter_H == '0) && (counter_V == V_VB_ROW);

  // Syncs and pixel drive share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync <= ~HSYNC_ACTIVE;
      vsync <= ~VSYNC_ACTIVE;
      rgb   <= RGB_BLACK;
    end else begin
      hsync <= h_sync_win ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync <= v_sync_win ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      rgb   <= (display_on && colour) ? RGB_WHITE : RGB_BLACK;
    end
  end

  // Count frames at each vblank; flip the animation phase every ANIM_DIV frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt  <= '0;
      anim_phase <= 1'b0;
    end else if (vblank_start) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt  <= '0;
        anim_phase <= ~anim_phase;
      end else begin
        frame_cnt  <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced screen so many frames fit in a
// short run. A driver issues reset/colour each clk and queues the expected
// post-edge outputs; a monitor pops and compares on the falling edge.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
  localparam int AD = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  typedef struct {
    int       h, v;
    bit       hs, vs;
    bit [5:0] rgb;
    bit       disp, vb, anim, anim1;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic colour = 1'b0;

  logic [9:0] counter_H, counter_V, counter_H2, counter_V2;
  logic       hsync, vsync, display_on, vblank_start, anim_phase;
  logic       hsync2, vsync2, display_on2, vblank_start2, anim_phase2;
  logic [5:0] rgb, rgb2;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ANIM_DIV(AD)
  ) dut (
    .clk(clk), .reset(reset), .colour(colour),
    .counter_H(counter_H), .counter_V(counter_V),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .display_on(display_on), .vblank_start(vblank_start),
    .anim_phase(anim_phase)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ANIM_DIV(1)
  ) dut1 (
    .clk(clk), .reset(reset), .colour(colour),
    .counter_H(counter_H2), .counter_V(counter_V2),
    .hsync(hsync2), .vsync(vsync2), .rgb(rgb2),
    .display_on(display_on2), .vblank_start(vblank_start2),
    .anim_phase(anim_phase2)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: linear pixel index since the last reset edge.
  int t = 0;
  int pulses = 0;

  function automatic int cur_h();
    return t % HT;
  endfunction

  task automatic cyc(input bit r, input bit c);
    exp_t e;
    int ph, pv;
    reset  = r;
    colour = c;
    ph = t % HT;
    pv = (t / HT) % VT;
    if (!r) begin
      t = 0; pulses = 0;
      e.hs = 1'b1; e.vs = 1'b1; e.rgb = 6'h00;
    end else begin
      e.hs  = !(ph >= HV + HF && ph < HV + HF + HS);
      e.vs  = !(pv >= VV + VF && pv < VV + VF + VS);
      e.rgb = (ph < HV && pv < VV && c) ? 6'h3F : 6'h00;
      if (ph == 0 && pv == VV) pulses++;
      t++;
    end
    e.h     = t % HT;
    e.v     = (t / HT) % VT;
    e.disp  = (e.h < HV) && (e.v < VV);
    e.vb    = (e.h == 0) && (e.v == VV);
    e.anim  = ((pulses / AD) % 2) == 1;
    e.anim1 = (pulses % 2) == 1;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare both instances against the queued expectation.
  always begin
    exp_t e;
    logic [30:0] got_a, got_b, want_a, want_b;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      want_a = {10'(e.h), 10'(e.v), e.hs, e.vs, e.rgb, e.disp, e.vb, e.anim};
      want_b = {10'(e.h), 10'(e.v), e.hs, e.vs, e.rgb, e.disp, e.vb, e.anim1};
      got_a  = {counter_H, counter_V, hsync, vsync, rgb, display_on, vblank_start, anim_phase};
      got_b  = {counter_H2, counter_V2, hsync2, vsync2, rgb2, display_on2, vblank_start2, anim_phase2};
      checks++;
      if (got_a !== want_a) begin
        errors++;
        $display("FAIL outputs_div%0d @%0t got H=%0d V=%0d hs=%b vs=%b rgb=%h de=%b vb=%b ap=%b exp H=%0d V=%0d hs=%b vs=%b rgb=%h de=%b vb=%b ap=%b",
                 AD, $time, counter_H, counter_V, hsync, vsync, rgb, display_on, vblank_start, anim_phase,
                 e.h, e.v, e.hs, e.vs, e.rgb, e.disp, e.vb, e.anim);
      end
      checks++;
      if (got_b !== want_b) begin
        errors++;
        $display("FAIL outputs_div1 @%0t got H=%0d V=%0d hs=%b vs=%b rgb=%h de=%b vb=%b ap=%b exp H=%0d V=%0d hs=%b vs=%b rgb=%h de=%b vb=%b ap=%b",
                 $time, counter_H2, counter_V2, hsync2, vsync2, rgb2, display_on2, vblank_start2, anim_phase2,
                 e.h, e.v, e.hs, e.vs, e.rgb, e.disp, e.vb, e.anim1);
      end
    end
  end

  initial begin
    // Reset held for a few clks with noise on colour.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'($urandom));
    // Constant white: full first line/frame plus a line of the next.
    for (int i = 0; i < FR + HT; i++) cyc(1'b1, 1'b1);
    // Colour follows counter_H[0]: rgb toggles every clk, one clk late.
    for (int i = 0; i < FR; i++) cyc(1'b1, 1'(cur_h() % 2));
    // Long random-colour run covering many vblanks and anim toggles.
    for (int i = 0; i < 30 * FR; i++) cyc(1'b1, 1'($urandom));
    // One-clk reset landing inside the hsync pulse.
    for (int i = 0; i < HT && cur_h() != HV + HF + 1; i++) cyc(1'b1, 1'($urandom));
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 2 * HT; i++) cyc(1'b1, 1'b1);
    // Random colour with sporadic resets.
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(199) == 0) ? 1'b0 : 1'b1, 1'($urandom));
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
